// File: rtl/pc_fetch.sv
// Program-counter fetch unit: reads opcode/operand from an external ROM,
// steps FETCH -> EXEC per instruction, and parks in HALT on the halt opcode.
module pc_fetch #(
    parameter int unsigned           ADDR_W  = 12,
    parameter int unsigned           DATA_W  = 8,
    parameter logic [DATA_W/2-1:0]   HALT_OP = 4'hF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [ADDR_W-1:0]     load_addr,
    output logic [ADDR_W-1:0]     dire,
    input  logic [DATA_W-1:0]     codigo,
    output logic [DATA_W/2-1:0]   instr,
    output logic [DATA_W/2-1:0]   oprnd,
    output logic                  valid,
    output logic                  wrap,
    output logic                  halted
);

    localparam int unsigned HALF_W = DATA_W / 2;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [HALF_W-1:0]   opcode;

    assign dire   = pc;
    assign opcode = codigo[DATA_W-1:HALF_W];

    // Priority: reset, then jump, then the enabled fetch/exec sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            instr  <= '0;
            oprnd  <= '0;
            valid  <= 1'b0;
            wrap   <= 1'b0;
            halted <= 1'b0;
            state  <= FETCH;
        end else if (load) begin
            pc     <= load_addr;
            valid  <= 1'b0;
            wrap   <= 1'b0;
            halted <= 1'b0;
            state  <= FETCH;
        end else begin
            valid <= 1'b0;
            wrap  <= 1'b0;
            if (enable) begin
                case (state)
                    FETCH: begin
                        instr <= opcode;
                        oprnd <= codigo[HALF_W-1:0];
                        valid <= 1'b1;
                        if (opcode == HALT_OP) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= EXEC;
                        end
                    end
                    EXEC: begin
                        pc    <= pc + ADDR_W'(1);
                        wrap  <= &pc;
                        state <= FETCH;
                    end
                    default: begin
                        // HALT: everything holds until load or reset
                    end
                endcase
            end
        end
    end

endmodule
